// File: rtl/sram_pkg.sv
// Shared types and defaults for the 32-bit pipeline to 16-bit external SRAM bridge.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DATA_BASE_DEFAULT   = 1024;
  localparam int unsigned WAIT_CYCLES_DEFAULT = 5;

  typedef struct packed {
    state_t     state;
    logic [3:0] wait_cnt;
    logic       dq_oe;
  } sram_dbg_t;

endpackage

// File: rtl/sram_if.sv
// Pipeline-side request bus of the SRAM controller.
interface sram_if;
  import sram_pkg::*;

  // Handshake: a request is wr_en|rd_en held by the MEM stage. While a request
  // is present, ready low freezes the pipeline; the cycle with ready high and a
  // request present completes it. The controller latches address/data/op when it
  // accepts, so dropping the request mid-access does not abort the transfer.
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;
  sram_dbg_t   dbg;

  modport master (
    output wr_en, rd_en, address, writeData,
    input  readData, ready, dbg
  );

  modport slave (
    input  wr_en, rd_en, address, writeData,
    output readData, ready, dbg
  );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses (low half, then
// high half), each held for WAIT_CYCLES clocks, stalling the pipeline meanwhile.
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter int unsigned DATA_BASE   = DATA_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  sram_if.slave       bus,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        op_wr_q;
  logic [16:0] word_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] req_off;
  logic        req;
  logic        phase_end;
  logic        in_access;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign req       = bus.wr_en | bus.rd_en;
  assign req_off   = bus.address - 32'(DATA_BASE);
  assign phase_end = (cnt_q == LAST_CNT);

  // Only the 512 KB word offset matters; higher bits wrap, low bits are alignment.
  wire unused_off = &{1'b0, req_off[31:19], req_off[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = LOW;
      LOW:     if (phase_end) state_d = HIGH;
      HIGH:    if (phase_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (req) begin
            op_wr_q <= bus.wr_en;  // write wins when both are asserted
            word_q  <= req_off[18:2];
            wdata_q <= bus.writeData;
          end
        end
        LOW, HIGH: begin
          cnt_q <= phase_end ? 4'd0 : cnt_q + 4'd1;
          if (phase_end && !op_wr_q) begin
            if (state_q == LOW) rdata_q[15:0]  <= SRAM_DQ;
            else                rdata_q[31:16] <= SRAM_DQ;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign in_access = (state_q == LOW) || (state_q == HIGH);
  assign dq_oe     = in_access && op_wr_q;
  assign dq_out    = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];

  assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
  assign SRAM_WE_N = ~dq_oe;
  assign SRAM_ADDR = in_access ? {word_q, (state_q == HIGH)} : 18'd0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign bus.ready    = ~req | (state_q == DONE);
  assign bus.readData = rdata_q;
  assign bus.dbg      = {state_q, cnt_q, dq_oe};

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: behavioural 512 KB x16 SRAM, vector table,
// hand-written corner sequences and a randomized run against a word-level model.
module sram_model (
  input  logic        clk,
  input  logic [17:0] addr,
  inout  wire  [15:0] dq,
  input  logic        we_n,
  input  logic        ce_n,
  input  logic        oe_n,
  input  logic        ub_n,
  input  logic        lb_n
);
  logic [15:0] mem [0:262143];

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
  end

  assign dq = (!ce_n && !oe_n && we_n) ? mem[addr] : 16'bz;

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[addr][7:0]  <= dq[7:0];
      if (!ub_n) mem[addr][15:8] <= dq[15:8];
    end
  end
endmodule

module tb_sram_controller;
  import sram_pkg::*;

  localparam int W       = 5;
  localparam int LAT     = 2 * W + 1;
  localparam int MAX_CYC = 64;
  localparam int TR      = 16;
  localparam int NV      = 8;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    logic [17:0] exp_lo;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

  sram_if bus();

  sram_controller #(.WAIT_CYCLES(W), .DATA_BASE(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_ADDR (sram_addr),
    .SRAM_DQ   (sram_dq),
    .SRAM_WE_N (sram_we_n),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_OE_N (sram_oe_n)
  );

  sram_model u_mem (
    .clk  (clk),
    .addr (sram_addr),
    .dq   (sram_dq),
    .we_n (sram_we_n),
    .ce_n (sram_ce_n),
    .oe_n (sram_oe_n),
    .ub_n (sram_ub_n),
    .lb_n (sram_lb_n)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard state and reference model
  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_q[$];
  logic [15:0] ref_mem [int unsigned];
  logic [31:0] last_rd;

  logic        tr_ready [TR];
  logic        tr_we_n  [TR];
  logic        tr_oe    [TR];
  logic [17:0] tr_addr  [TR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Half-word index of the low half: byte offset from base, wrapped to 512 KB.
  function automatic int unsigned ref_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr - 32'd1024) % 32'h80000;
    return off / 2;
  endfunction

  function automatic logic [15:0] ref_rd(input int unsigned idx);
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return 16'h0000;
  endfunction

  // Driver: present a request at cycle 0 and wait for completion, tracing pins.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] data, input int drop_at,
                            output int lat, output logic [31:0] rdv);
    bus.wr_en     = wr;
    bus.rd_en     = rd;
    bus.address   = addr;
    bus.writeData = data;
    lat = -1;
    rdv = '0;
    for (int c = 0; c < TR; c++) begin
      tr_ready[c] = 1'bx; tr_we_n[c] = 1'bx; tr_oe[c] = 1'bx; tr_addr[c] = 'x;
    end
    for (int c = 0; c < MAX_CYC; c++) begin
      @(negedge clk);
      if (c < TR) begin
        tr_ready[c] = bus.ready;
        tr_we_n[c]  = sram_we_n;
        tr_oe[c]    = bus.dbg.dq_oe;
        tr_addr[c]  = sram_addr;
      end
      if ((drop_at < 0) ? (bus.ready === 1'b1) : (bus.dbg.state == DONE)) begin
        lat = c;
        rdv = bus.readData;
        break;
      end
      if (c == drop_at) begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL access_timeout: addr %0h no completion within %0d cycles", addr, MAX_CYC);
    end
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  // Expected pin timeline derived from the phase rules: LOW cycles 1..W, HIGH W+1..2W.
  task automatic check_trace(input string tag, input logic is_wr, input logic [17:0] lo);
    for (int c = 0; c <= LAT; c++) begin
      logic        exp_rdy;
      logic        exp_oe;
      logic [17:0] exp_a;
      exp_rdy = (c == LAT);
      exp_oe  = is_wr && (c >= 1) && (c <= 2 * W);
      if (c >= 1 && c <= W)          exp_a = lo;
      else if (c > W && c <= 2 * W)  exp_a = lo + 18'd1;
      else                           exp_a = 18'd0;
      check($sformatf("%s_ready_c%0d", tag, c), tr_ready[c], exp_rdy);
      check($sformatf("%s_we_n_c%0d", tag, c), tr_we_n[c], !exp_oe);
      check($sformatf("%s_dq_oe_c%0d", tag, c), tr_oe[c], exp_oe);
      check($sformatf("%s_addr_c%0d", tag, c), tr_addr[c], exp_a);
    end
  endtask

  vec_t        vecs [NV];
  int          lat, lat2;
  logic [31:0] rdv, expv;
  logic        r_wr, r_rd;
  logic [31:0] r_addr, r_data;
  int          r_drop;
  int unsigned idx;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_rd = '0;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.address = '0;
    bus.writeData = '0;

    vecs[0] = '{1'b1, 1'b0, 32'd1024,    32'hDEADBEEF, 32'h00000000, 18'h00000};
    vecs[1] = '{1'b0, 1'b1, 32'd1024,    32'h00000000, 32'hDEADBEEF, 18'h00000};
    vecs[2] = '{1'b1, 1'b1, 32'd1028,    32'h12345678, 32'hDEADBEEF, 18'h00002};
    vecs[3] = '{1'b0, 1'b1, 32'd1028,    32'h00000000, 32'h12345678, 18'h00002};
    vecs[4] = '{1'b1, 1'b0, 32'd1000,    32'hCAFEF00D, 32'h12345678, 18'h3FFF4};
    vecs[5] = '{1'b0, 1'b1, 32'd1000,    32'h00000000, 32'hCAFEF00D, 18'h3FFF4};
    vecs[6] = '{1'b1, 1'b0, 32'h000803FC, 32'h0BADC0DE, 32'hCAFEF00D, 18'h3FFFE};
    vecs[7] = '{1'b0, 1'b1, 32'h000803FC, 32'h00000000, 32'h0BADC0DE, 18'h3FFFE};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.ready, 1'b1);
    check("rst_readData", bus.readData, 32'h0);
    check("rst_sram_addr", sram_addr, 18'h0);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_dq_oe", bus.dbg.dq_oe, 1'b0);
    check("rst_state", bus.dbg.state, IDLE);
    check("tied_pins", {sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Vector table; the first request lands on the first edge after reset release
    for (int i = 0; i < NV; i++) begin
      run_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, -1, lat, rdv);
      check($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_readData", i), rdv, vecs[i].exp_rdata);
      check_trace($sformatf("vec%0d", i), vecs[i].wr, vecs[i].exp_lo);
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_mem_lo", i), u_mem.mem[vecs[i].exp_lo], vecs[i].data[15:0]);
        check($sformatf("vec%0d_mem_hi", i), u_mem.mem[vecs[i].exp_lo + 18'd1], vecs[i].data[31:16]);
        ref_mem[ref_idx(vecs[i].addr)]     = vecs[i].data[15:0];
        ref_mem[ref_idx(vecs[i].addr) + 1] = vecs[i].data[31:16];
      end else begin
        last_rd = vecs[i].exp_rdata;
      end
    end

    // Stall timing on a read at 1032
    run_access(1'b0, 1'b1, 32'd1032, 32'h0, -1, lat, rdv);
    check("stall_latency", lat, LAT);
    check("stall_readData", rdv, {ref_rd(5), ref_rd(4)});
    check_trace("stall", 1'b0, 18'd4);
    last_rd = {ref_rd(5), ref_rd(4)};

    // Back-to-back reads: ready pulses at absolute cycles 11 and 23
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, -1, lat, rdv);
    check("b2b_first_cycle", lat, 11);
    check("b2b_first_data", rdv, 32'hDEADBEEF);
    run_access(1'b0, 1'b1, 32'd1028, 32'h0, -1, lat2, rdv);
    check("b2b_second_cycle", lat + 1 + lat2, 23);
    check("b2b_second_data", rdv, 32'h12345678);
    last_rd = 32'h12345678;

    // Randomized traffic against the word-level reference
    for (int k = 0; k < 40; k++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_rd = r_wr ? 1'($urandom_range(0, 1)) : 1'b1;
      if ($urandom_range(0, 7) == 0) r_addr = 32'd1024 - 32'(4 * $urandom_range(1, 8));
      else                           r_addr = 32'd1024 + 32'(4 * $urandom_range(0, 15));
      r_data = $urandom;
      r_drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
      idx = ref_idx(r_addr);
      if (r_wr) begin
        ref_mem[idx]     = r_data[15:0];
        ref_mem[idx + 1] = r_data[31:16];
      end else begin
        last_rd = {ref_rd(idx + 1), ref_rd(idx)};
      end
      exp_q.push_back(last_rd);
      run_access(r_wr, r_rd, r_addr, r_data, r_drop, lat, rdv);
      check($sformatf("rnd%0d_latency", k), lat, LAT);
      expv = exp_q.pop_front();
      check($sformatf("rnd%0d_readData", k), rdv, expv);
      if (r_wr) begin
        check($sformatf("rnd%0d_mem_lo", k), u_mem.mem[18'(idx)], ref_rd(idx));
        check($sformatf("rnd%0d_mem_hi", k), u_mem.mem[18'(idx + 1)], ref_rd(idx + 1));
      end
    end

    // Reset in cycle 7 of a write: pins must release without a clock edge
    bus.wr_en     = 1'b1;
    bus.rd_en     = 1'b0;
    bus.address   = 32'd2048;
    bus.writeData = 32'hA1B2C3D4;
    repeat (7) @(posedge clk);
    #1;
    check("rstmid_pre_we_n", sram_we_n, 1'b0);
    rst = 1'b1;
    bus.wr_en = 1'b0;
    #1;
    check("rstmid_we_n", sram_we_n, 1'b1);
    check("rstmid_dq_oe", bus.dbg.dq_oe, 1'b0);
    check("rstmid_sram_addr", sram_addr, 18'h0);
    check("rstmid_state", bus.dbg.state, IDLE);
    check("rstmid_readData", bus.readData, 32'h0);
    check("rstmid_lo_kept", u_mem.mem[512], 16'hC3D4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_rd = '0;
    run_access(1'b1, 1'b0, 32'd2052, 32'h55AA33CC, -1, lat, rdv);
    check("post_rst_wr_latency", lat, LAT);
    check("post_rst_wr_readData", rdv, 32'h0);
    check("post_rst_mem_lo", u_mem.mem[514], 16'h33CC);
    check("post_rst_mem_hi", u_mem.mem[515], 16'h55AA);
    run_access(1'b0, 1'b1, 32'd2052, 32'h0, -1, lat, rdv);
    check("post_rst_rd_latency", lat, LAT);
    check("post_rst_rd_data", rdv, 32'h55AA33CC);

    // Idle for 20 cycles
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("idle_ready_c%0d", c), bus.ready, 1'b1);
      check($sformatf("idle_we_n_c%0d", c), sram_we_n, 1'b1);
      check($sformatf("idle_dq_oe_c%0d", c), bus.dbg.dq_oe, 1'b0);
    end
    check("idle_readData_held", bus.readData, 32'h55AA33CC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 5: clock cycles each 16-bit SRAM access is held; legal range 1..15.
REQ-002 Parameter DATA_BASE, default 1024: byte address that maps to SRAM word 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_en  input  1  MEM-stage write request.
REQ-006 rd_en  input  1  MEM-stage read request.
REQ-007 address  input  32  byte address from ALU result, word-aligned.
REQ-008 writeData  input  32  store data.
REQ-009 readData  output  32  load data, registered.
REQ-010 ready  output  1  low = freeze pipeline; high = request complete or no request pending.
REQ-011 SRAM_ADDR  output  18  external SRAM half-word address.
REQ-012 SRAM_DQ  inout  16  external SRAM data bus.
REQ-013 SRAM_WE_N  output  1  external write enable, active low.
REQ-014 SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  tied 0.

Function
REQ-015 States SHALL be IDLE, LOW, HIGH, DONE.
REQ-016 In IDLE with wr_en|rd_en = 1, the block SHALL latch address, writeData and op, clear the wait counter, and enter LOW.
REQ-017 If wr_en and rd_en are both 1, the block SHALL perform a write.
REQ-018 The SRAM address SHALL be off = address - DATA_BASE (32-bit, wrap ignored), with SRAM_ADDR = {off[18:2], h}: h = 0 in LOW, h = 1 in HIGH.
REQ-019 LOW and HIGH SHALL each last exactly WAIT_CYCLES cycles, counted by a 4-bit counter that is cleared on each phase entry.
REQ-020 In a write, SRAM_DQ SHALL drive writeData[15:0] in LOW and writeData[31:16] in HIGH, and SRAM_WE_N SHALL be 0 for all cycles of both phases.
REQ-021 In a read, SRAM_DQ SHALL be high-Z and SRAM_WE_N 1; SRAM_DQ is sampled on the last cycle of LOW into readData[15:0] and on the last cycle of HIGH into readData[31:16].
REQ-022 Outside LOW and HIGH, SRAM_DQ SHALL be high-Z and SRAM_WE_N 1.
REQ-023 DONE SHALL last 1 cycle and then return to IDLE.
REQ-024 ready SHALL be combinational: ready = ~(wr_en|rd_en) | (state==DONE).
REQ-025 Latency: with the request first seen in IDLE at cycle 0, ready SHALL be 1 in cycle 2*WAIT_CYCLES+1 (cycle 11 at the default).
REQ-026 Back-to-back requests: a request still asserted in the IDLE cycle after DONE SHALL start a new access; the pipeline advances on the DONE edge.
REQ-027 A request deasserted mid-access SHALL not abort it; the access completes on the latched values and readData is updated.
REQ-028 readData SHALL hold its value until the next read completes.
REQ-029 An address below DATA_BASE SHALL wrap modulo 2^19 bytes with no error output.

Reset
REQ-030 When rst = 1, the block SHALL immediately (asynchronously) force state IDLE, counter 0, readData 0, SRAM_WE_N 1, SRAM_DQ high-Z and SRAM_ADDR 0.
REQ-031 Reset mid-write SHALL abandon the access; a half-word already written is not rolled back.
REQ-032 The block SHALL accept a request on the first rising edge after rst deasserts.

Structure
REQ-033 Package sram_pkg SHALL hold the state enum, DATA_BASE_DEFAULT = 1024 and WAIT_CYCLES_DEFAULT = 5.
REQ-034 The RTL SHALL contain no sub-modules; the bench SHALL use behavioural sub-module sram_model (512 KB, 16-bit, asynchronous read).

Verification
REQ-035 Write then read: wr address 1024, data 0xDEADBEEF, then rd 1024 -> SRAM[0] = 0xBEEF, SRAM[1] = 0xDEAD, readData 0xDEADBEEF, ready high at cycle 11 of each access.
REQ-036 Stall timing: rd_en held at address 1032 -> ready low cycles 0-10, high at cycle 11; SRAM_ADDR 4 in cycles 1-5, 5 in cycles 6-10.
REQ-037 Simultaneous: wr_en = rd_en = 1, address 1028, data 0x12345678 -> write performed, SRAM[2] = 0x5678, SRAM[3] = 0x1234, readData unchanged.
REQ-038 Reset mid-op: rst asserted at cycle 7 of a write -> SRAM_WE_N 1 and SRAM_DQ high-Z with no clock edge; next request completes normally at cycle 11.
REQ-039 Idle: wr_en = rd_en = 0 for 20 cycles -> ready 1, SRAM_WE_N 1, SRAM_DQ high-Z throughout.
REQ-040 Back-to-back reads at 1024 then 1028 -> ready pulses at cycles 11 and 23, readData correct after each.
